mux_nto1_scan: RTL and testbench
================================

MUX_NTO1_SCAN -- requirements
Module: mux_nto1_scan

Interface
REQ-001 The block SHALL have parameter W, default 8: data width per channel in bits, W >= 1.
REQ-002 The block SHALL have parameter N, default 4: channel count, 2 <= N <= 256.
REQ-003 The block SHALL have parameter DWELL, default 1: enabled cycles spent on each channel in auto mode, 1 <= DWELL <= 65535.
REQ-004 The block SHALL have localparam SW = $clog2(N): select and channel-index width.
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock, rising edge.
REQ-006 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-007 The block SHALL have port din, input, N*W bits: flattened channel data; channel k is din[k*W +: W].
REQ-008 The block SHALL have port sel, input, SW bits: channel select in manual mode.
REQ-009 The block SHALL have port mode, input, 1 bit: 0 = manual select, 1 = auto-scan.
REQ-010 The block SHALL have port en, input, 1 bit: cycle enable; when low, all state and outputs hold.
REQ-011 The block SHALL have port y, output, W bits: registered selected data.
REQ-012 The block SHALL have port y_ch, output, SW bits: registered index of the channel driving y.
REQ-013 The block SHALL have port y_valid, output, 1 bit: y/y_ch were updated from a legal channel on the last enabled cycle.
REQ-014 The block SHALL have port wrap, output, 1 bit: one-cycle pulse when the auto-scan channel index wraps from the last channel back to the first.

Function
REQ-015 Every edge with en=1 SHALL register y <= selected channel data, y_ch <= selected index; latency 1 cycle from din/sel to y.
REQ-016 In manual mode with sel < N, the selected channel SHALL be sel and y_valid SHALL be set to 1.
REQ-017 In manual mode with sel >= N (possible when N is not a power of 2), y SHALL load 0, y_ch SHALL load sel, and y_valid SHALL load 0.
REQ-018 In auto mode, the selected channel SHALL be an internal index ch, and a dwell counter dc SHALL count enabled cycles 0..DWELL-1.
REQ-019 In auto mode, when dc = DWELL-1 on an enabled cycle, ch SHALL advance to the next channel and dc SHALL clear; otherwise dc SHALL increment.
REQ-020 In auto mode, advancing from ch = N-1 SHALL wrap ch to 0 and assert wrap for exactly the following cycle; wrap SHALL be 0 at all other times, including when en=0.
REQ-021 On the first enabled cycle after mode changes from 0 to 1, ch and dc SHALL be treated as 0: din[0] is loaded and dc becomes 1, or ch advances immediately if DWELL=1.
REQ-022 Changing mode from 1 to 0 SHALL take effect on the same enabled cycle; ch and dc SHALL be preserved but unused.
REQ-023 With en=0, y, y_ch, y_valid, ch and dc SHALL hold, and wrap SHALL be 0.
REQ-024 The mode-change detect register SHALL update only on enabled cycles.

Reset
REQ-025 When rst=1 at a clock edge, y, y_ch, y_valid and wrap SHALL become 0, regardless of en.
REQ-026 When rst=1 at a clock edge, ch, dc and the mode-change detect register SHALL become 0, regardless of en.
REQ-027 Reset SHALL have priority over en and mode, and SHALL abort a dwell or scan in progress with no pending wrap.
REQ-028 The first enabled cycle after reset with mode=1 SHALL select channel 0.

Configuration
REQ-029 When macro MUX_SCAN_SKIP_EN is defined, the block SHALL add input port ch_mask, N bits, where bit k = 1 marks channel k as included in the scan.
REQ-030 With MUX_SCAN_SKIP_EN, on each advance ch SHALL move to the next index with its mask bit set, searching upward with wrap-around.
REQ-031 With MUX_SCAN_SKIP_EN, wrap SHALL pulse whenever the search passes index N-1.
REQ-032 With MUX_SCAN_SKIP_EN, if the current ch is masked out, the advance SHALL occur on the next enabled cycle regardless of dc.
REQ-033 With MUX_SCAN_SKIP_EN and ch_mask = 0 in auto mode, y, y_ch and ch SHALL hold, y_valid SHALL load 0, and wrap SHALL stay 0.
REQ-034 With MUX_SCAN_SKIP_EN, manual mode SHALL ignore ch_mask.
REQ-035 Without MUX_SCAN_SKIP_EN, the ch_mask port SHALL be absent and all N channels SHALL be scanned in order.

Verification
REQ-036 Manual mode: N=4, W=8, din = {8'h44, 8'h33, 8'h22, 8'h11}, en=1, sel stepped 0,1,2,3 at one value per cycle -> y = 11, 22, 33, 44 each one cycle later, y_valid=1, y_ch matching sel.
REQ-037 Illegal select: N=3, sel=3 -> next cycle y=0, y_ch=3, y_valid=0; then sel=1 -> y=din[1], y_valid=1.
REQ-038 Auto-scan: N=4, DWELL=2, mode=1, en=1 for 10 cycles -> y_ch sequence 0,0,1,1,2,2,3,3,0,0, with wrap high for exactly the one cycle after ch leaves 3.
REQ-039 Enable and reset mid-scan: N=4, DWELL=2, mode=1, en=1 until y_ch=2, then en=0 for 3 cycles -> all outputs hold and wrap=0. Then raise rst for 1 cycle while en=1 -> all outputs 0, and the next enabled cycle gives y_ch=0.
REQ-040 Skip mask: with MUX_SCAN_SKIP_EN defined, N=4, DWELL=1, ch_mask=4'b1010 -> y_ch alternates 1,3,1,3 with wrap after each 3. Then ch_mask=0 -> y holds and y_valid=0.

Source files
------------

// File: rtl/mux_nto1_scan.sv
// N:1 registered data mux, manual select or auto-scan; define MUX_SCAN_SKIP_EN to add a ch_mask scan-skip port.
// Latency: 1 cycle from din/sel to y, y_ch, y_valid.
// Backpressure: none; en low freezes all state and outputs and forces wrap low.
module mux_nto1_scan #(
    parameter int W     = 8,
    parameter int N     = 4,
    parameter int DWELL = 1,
    localparam int SW   = $clog2(N)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [N*W-1:0] din,
    input  logic [SW-1:0]  sel,
    input  logic           mode,
    input  logic           en,
`ifdef MUX_SCAN_SKIP_EN
    input  logic [N-1:0]   ch_mask,
`endif
    output logic [W-1:0]   y,
    output logic [SW-1:0]  y_ch,
    output logic           y_valid,
    output logic           wrap
);

    localparam int DCW = (DWELL > 1) ? $clog2(DWELL) : 1;

    logic [W-1:0]   ch_dat [N];
    logic           mode_q;
    logic [SW-1:0]  ch, auto_ch, ch_nxt;
    logic [DCW-1:0] dc, auto_dc, dc_nxt;
    logic [W-1:0]   y_nxt;
    logic [SW-1:0]  y_ch_nxt;
    logic           y_valid_nxt, wrap_nxt, adv;

    for (genvar k = 0; k < N; k++) begin : g_unpack
        assign ch_dat[k] = din[k*W +: W];
    end

`ifdef MUX_SCAN_SKIP_EN
    logic [SW-1:0]  cur_ch;
    logic [DCW-1:0] dc_e;
    logic [SW:0]    skip_a, skip_b;

    // Returns {passed N-1, next included index} searching upward from cur.
    function automatic logic [SW:0] next_incl(input logic [SW-1:0] cur, input logic [N-1:0] msk);
        logic [SW:0] r;
        logic        found;
        r     = {1'b0, cur};
        found = 1'b0;
        for (int i = 1; i <= N; i++) begin
            if (!found && msk[(int'(cur) + i) % N]) begin
                found = 1'b1;
                r     = {(int'(cur) + i >= N), SW'((int'(cur) + i) % N)};
            end
        end
        return r;
    endfunction
`endif

    always_comb begin
        // A fresh entry into auto mode restarts the scan from channel 0.
        auto_ch     = mode_q ? ch : '0;
        auto_dc     = mode_q ? dc : '0;
        adv         = 1'b0;
        ch_nxt      = ch;
        dc_nxt      = dc;
        y_nxt       = y;
        y_ch_nxt    = y_ch;
        y_valid_nxt = y_valid;
        wrap_nxt    = 1'b0;
`ifdef MUX_SCAN_SKIP_EN
        cur_ch      = auto_ch;
        dc_e        = auto_dc;
        skip_a      = '0;
        skip_b      = '0;
`endif
        if (!mode) begin
            y_ch_nxt = sel;
            if (int'(sel) < N) begin
                y_nxt       = ch_dat[sel];
                y_valid_nxt = 1'b1;
            end else begin
                y_nxt       = '0;
                y_valid_nxt = 1'b0;
            end
        end else begin
`ifdef MUX_SCAN_SKIP_EN
            if (ch_mask == '0) begin
                y_valid_nxt = 1'b0;
            end else begin
                // A masked-out current channel is skipped without waiting for the dwell.
                if (!ch_mask[auto_ch]) begin
                    skip_a = next_incl(auto_ch, ch_mask);
                    cur_ch = skip_a[SW-1:0];
                    dc_e   = '0;
                end
                adv         = (dc_e == DCW'(DWELL - 1));
                skip_b      = next_incl(cur_ch, ch_mask);
                y_nxt       = ch_dat[cur_ch];
                y_ch_nxt    = cur_ch;
                y_valid_nxt = 1'b1;
                ch_nxt      = adv ? skip_b[SW-1:0] : cur_ch;
                dc_nxt      = adv ? '0 : dc_e + DCW'(1);
                wrap_nxt    = skip_a[SW] | (adv & skip_b[SW]);
            end
`else
            adv         = (auto_dc == DCW'(DWELL - 1));
            y_nxt       = ch_dat[auto_ch];
            y_ch_nxt    = auto_ch;
            y_valid_nxt = 1'b1;
            ch_nxt      = adv ? ((auto_ch == SW'(N - 1)) ? '0 : auto_ch + SW'(1)) : auto_ch;
            dc_nxt      = adv ? '0 : auto_dc + DCW'(1);
            wrap_nxt    = adv && (auto_ch == SW'(N - 1));
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            y       <= '0;
            y_ch    <= '0;
            y_valid <= 1'b0;
            wrap    <= 1'b0;
            ch      <= '0;
            dc      <= '0;
            mode_q  <= 1'b0;
        end else if (en) begin
            y       <= y_nxt;
            y_ch    <= y_ch_nxt;
            y_valid <= y_valid_nxt;
            wrap    <= wrap_nxt;
            ch      <= ch_nxt;
            dc      <= dc_nxt;
            mode_q  <= mode;
        end else begin
            wrap    <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mux_nto1_scan.sv
// Bench for mux_nto1_scan: three parameterisations (N4/D1, N3/D3, N4/D2) against a scan-position model.
module tb_mux_nto1_scan;

    logic        clk = 1'b0;
    logic        rst, en, mode;
    logic [1:0]  sel;
    logic [31:0] din_bus;
    logic [3:0]  mask0;

    logic [7:0]  d_y [3];
    logic [1:0]  d_c [3];
    logic        d_v [3];
    logic        d_w [3];

    int checks = 0;
    int errors = 0;
    bit chk_on = 1'b0;
    bit skip_phase = 1'b0;

    // Model: position in a continuous auto run is k enabled cycles -> channel (k/DWELL)%N.
    int          n_of [3] = '{4, 3, 4};
    int          d_of [3] = '{1, 3, 2};
    logic [7:0]  m_y  [3];
    int          m_ch [3];
    logic        m_v  [3];
    logic        m_w  [3];
    int          m_k  [3];
    int          mc;

    always #5 clk = ~clk;

    mux_nto1_scan #(.W(8), .N(4), .DWELL(1)) dut0 (
        .clk(clk), .rst(rst), .din(din_bus), .sel(sel), .mode(mode), .en(en),
`ifdef MUX_SCAN_SKIP_EN
        .ch_mask(mask0),
`endif
        .y(d_y[0]), .y_ch(d_c[0]), .y_valid(d_v[0]), .wrap(d_w[0])
    );

    mux_nto1_scan #(.W(8), .N(3), .DWELL(3)) dut1 (
        .clk(clk), .rst(rst), .din(din_bus[23:0]), .sel(sel), .mode(mode), .en(en),
`ifdef MUX_SCAN_SKIP_EN
        .ch_mask(3'b111),
`endif
        .y(d_y[1]), .y_ch(d_c[1]), .y_valid(d_v[1]), .wrap(d_w[1])
    );

    mux_nto1_scan #(.W(8), .N(4), .DWELL(2)) dut2 (
        .clk(clk), .rst(rst), .din(din_bus), .sel(sel), .mode(mode), .en(en),
`ifdef MUX_SCAN_SKIP_EN
        .ch_mask(4'b1111),
`endif
        .y(d_y[2]), .y_ch(d_c[2]), .y_valid(d_v[2]), .wrap(d_w[2])
    );

    task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s dut%0d: got %0h expected %0h at %0t", name, idx, act, exp, $time);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    always @(posedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (rst) begin
                m_y[i] = 8'h00; m_ch[i] = 0; m_v[i] = 1'b0; m_w[i] = 1'b0; m_k[i] = 0;
            end else if (!en) begin
                m_w[i] = 1'b0;
            end else if (!mode) begin
                m_k[i]  = 0;
                m_w[i]  = 1'b0;
                m_ch[i] = int'(sel);
                if (int'(sel) < n_of[i]) begin
                    m_y[i] = din_bus[8*sel +: 8];
                    m_v[i] = 1'b1;
                end else begin
                    m_y[i] = 8'h00;
                    m_v[i] = 1'b0;
                end
            end else begin
                mc      = (m_k[i] / d_of[i]) % n_of[i];
                m_ch[i] = mc;
                m_y[i]  = din_bus[8*mc +: 8];
                m_v[i]  = 1'b1;
                m_w[i]  = ((m_k[i] % d_of[i]) == d_of[i] - 1) && (mc == n_of[i] - 1);
                m_k[i]  = m_k[i] + 1;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_on) begin
            for (int i = 0; i < 3; i++) begin
                if (!(skip_phase && i == 0)) begin
                    check("model_y", i, 32'(d_y[i]), 32'(m_y[i]));
                    check("model_ch", i, 32'(d_c[i]), 32'(m_ch[i][1:0]));
                    check("model_valid", i, 32'(d_v[i]), 32'(m_v[i]));
                    check("model_wrap", i, 32'(d_w[i]), 32'(m_w[i]));
                end
            end
        end
    end

    initial begin
        logic [7:0] man_y0 [5];
        logic [7:0] man_y1 [5];
        logic       man_v1 [5];
        logic [1:0] man_sel [5];
        logic [1:0] auto_ch [10];
        logic       auto_w [10];
        int         n;

        man_sel = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd1};
        man_y0  = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h22};
        man_y1  = '{8'h11, 8'h22, 8'h33, 8'h00, 8'h22};
        man_v1  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        auto_ch = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd2, 2'd2, 2'd3, 2'd3, 2'd0, 2'd0};
        auto_w  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};

        rst = 1'b1; en = 1'b0; mode = 1'b0; sel = 2'd0;
        din_bus = 32'h4433_2211; mask0 = 4'hf;
        step(); step();
        chk_on = 1'b1;
        for (int i = 0; i < 3; i++) begin
            check("rst_y", i, 32'(d_y[i]), 32'h0);
            check("rst_ch", i, 32'(d_c[i]), 32'h0);
            check("rst_valid", i, 32'(d_v[i]), 32'h0);
            check("rst_wrap", i, 32'(d_w[i]), 32'h0);
        end

        // Manual select, including an illegal select on the 3-channel instance.
        rst = 1'b0; en = 1'b1; mode = 1'b0;
        for (int s = 0; s < 5; s++) begin
            sel = man_sel[s];
            step();
            check("man_y", 0, 32'(d_y[0]), 32'(man_y0[s]));
            check("man_ch", 0, 32'(d_c[0]), 32'(man_sel[s]));
            check("man_valid", 0, 32'(d_v[0]), 32'h1);
            check("man_y", 1, 32'(d_y[1]), 32'(man_y1[s]));
            check("man_ch", 1, 32'(d_c[1]), 32'(man_sel[s]));
            check("man_valid", 1, 32'(d_v[1]), 32'(man_v1[s]));
        end

        // Auto scan with DWELL=2.
        mode = 1'b1;
        for (int s = 0; s < 10; s++) begin
            step();
            check("auto_ch", 2, 32'(d_c[2]), 32'(auto_ch[s]));
            check("auto_wrap", 2, 32'(d_w[2]), 32'(auto_w[s]));
        end

        // Hold with en low mid-scan, then reset with en high.
        mode = 1'b0; sel = 2'd0;
        step();
        mode = 1'b1;
        n = 0;
        while (d_c[2] != 2'd2 && n < 20) begin
            step();
            n++;
        end
        check("reach_ch2", 2, 32'(d_c[2]), 32'h2);
        en = 1'b0; mode = 1'b0;
        for (int s = 0; s < 3; s++) begin
            step();
            check("hold_ch", 2, 32'(d_c[2]), 32'h2);
            check("hold_y", 2, 32'(d_y[2]), 32'h33);
            check("hold_valid", 2, 32'(d_v[2]), 32'h1);
            check("hold_wrap", 2, 32'(d_w[2]), 32'h0);
        end
        mode = 1'b1; en = 1'b1; rst = 1'b1;
        step();
        check("mid_rst_y", 2, 32'(d_y[2]), 32'h0);
        check("mid_rst_ch", 2, 32'(d_c[2]), 32'h0);
        check("mid_rst_valid", 2, 32'(d_v[2]), 32'h0);
        rst = 1'b0;
        step();
        check("post_rst_ch", 2, 32'(d_c[2]), 32'h0);
        check("post_rst_y", 2, 32'(d_y[2]), 32'h11);
        check("post_rst_valid", 2, 32'(d_v[2]), 32'h1);

        // Random traffic against the model.
        for (int t = 0; t < 4000; t++) begin
            din_bus = $urandom;
            sel     = 2'($urandom_range(0, 3));
            en      = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 19) == 0) mode = ~mode;
            rst     = ($urandom_range(0, 99) == 0);
            step();
        end
        rst = 1'b0;

`ifdef MUX_SCAN_SKIP_EN
        begin
            logic [1:0] sk_ch [4];
            logic       sk_w  [4];
            logic [7:0] sk_y  [4];
            sk_ch = '{2'd1, 2'd3, 2'd1, 2'd3};
            sk_w  = '{1'b0, 1'b1, 1'b0, 1'b1};
            sk_y  = '{8'h22, 8'h44, 8'h22, 8'h44};
            skip_phase = 1'b1;
            rst = 1'b1; en = 1'b1; mode = 1'b1; mask0 = 4'b1010; din_bus = 32'h4433_2211;
            step();
            rst = 1'b0;
            for (int s = 0; s < 4; s++) begin
                step();
                check("skip_ch", 0, 32'(d_c[0]), 32'(sk_ch[s]));
                check("skip_wrap", 0, 32'(d_w[0]), 32'(sk_w[s]));
                check("skip_y", 0, 32'(d_y[0]), 32'(sk_y[s]));
            end
            mask0 = 4'b0000;
            step();
            check("nomask_y", 0, 32'(d_y[0]), 32'h44);
            check("nomask_ch", 0, 32'(d_c[0]), 32'h3);
            check("nomask_valid", 0, 32'(d_v[0]), 32'h0);
            check("nomask_wrap", 0, 32'(d_w[0]), 32'h0);
        end
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
